// File: rtl/uram_read_streamer.sv
// Burst read engine for a fixed-latency URAM port: walks sequential addresses,
// tracks in-flight reads in a valid/last shadow pipe and buffers returns in a FWFT FIFO.
module uram_read_streamer #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int READ_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_base,
    input  logic [ADDRESS_WIDTH-1:0] cmd_len,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(READ_LATENCY + 1);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] remaining_q, remaining_d;
    logic [READ_LATENCY-1:0]  sh_valid_q, sh_valid_d;
    logic [READ_LATENCY-1:0]  sh_last_q, sh_last_d;
    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    fifo_last_q, fifo_last_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]            occ_q, occ_d;

    logic [IW-1:0] inflight;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered occupancy/inflight only; a pop in this cycle frees a slot next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + IW'(sh_valid_q[i]);
        end
        credit_ok = (CW'(occ_q) + CW'(inflight)) < CW'(FIFO_DEPTH);
    end

    assign issue     = (state_q == ST_ISSUE) && credit_ok;
    assign push      = sh_valid_q[READ_LATENCY-1];
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;
    assign cmd_ready = reset_n && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d      = cmd_base;
                    remaining_d = cmd_len;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_valid_d    = '0;
        sh_last_d     = '0;
        sh_valid_d[0] = issue;
        sh_last_d[0]  = issue && (remaining_q == '0);
        for (int i = 1; i < READ_LATENCY; i++) begin
            sh_valid_d[i] = sh_valid_q[i-1];
            sh_last_d[i]  = sh_last_q[i-1];
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_dout;
            fifo_last_d[wr_ptr_q] = sh_last_q[READ_LATENCY-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            sh_valid_q  <= '0;
            sh_last_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            sh_valid_q  <= sh_valid_d;
            sh_last_q   <= sh_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // The address register drives the URAM directly; it only moves on accept or issue.
    assign mem_raddr = addr_q;
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign busy      = (state_q == ST_ISSUE) || (|sh_valid_q) || out_valid;

endmodule

// File: tb/tb_uram_read_streamer.sv
// Bench for uram_read_streamer: URAM model with mem[a] tagged by a, a queue-based
// expected-word model, a vector table, and hand-written latency/stall/reset sequences.
module tb_uram_read_streamer;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int RL = 2;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    always #5 clock = ~clock;

    uram_read_streamer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    // Memory contents: word a carries a in its low bits plus fixed tags in the upper bits.
    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return {20'h5A5A5, a, 20'hC3C3C, a};
    endfunction

    logic [DW-1:0] rd_pipe [RL];
    initial for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    always @(posedge clock) begin
        rd_pipe[0] <= f(mem_raddr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RL-1];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;

    int            n_popped = 0;
    int            burst_cnt = 0;
    logic [DW-1:0] burst_first = '0;
    logic [DW-1:0] burst_final = '0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    int ready_mode = 1; // 0 low, 1 high, 2 random, 3 toggle
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom);
            default: out_ready = !out_ready;
        endcase
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every popped word must be the next one the model expects.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                total++;
                if (!out_valid || out_data !== hold_d || out_last !== hold_l) begin
                    bad++;
                    $display("FAIL hold_stable actual=%b/%h/%b required=1/%h/%b",
                             out_valid, out_data, out_last, hold_d, hold_l);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word actual=%h last=%b required=none", out_data, out_last);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (out_data !== sb_e.data || out_last !== sb_e.last) begin
                        bad++;
                        $display("FAIL word actual=%h last=%b required=%h last=%b",
                                 out_data, out_last, sb_e.data, sb_e.last);
                    end
                end
                n_popped++;
                if (burst_cnt == 0) burst_first = out_data;
                burst_cnt++;
                if (out_last) burst_final = out_data;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l, output int t0);
        logic [AW-1:0] a;
        exp_t e;
        cmd_base  = b;
        cmd_len   = l;
        cmd_valid = 1'b1;
        t0 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout actual=no_ready required=ready");
        end else begin
            for (int k = 0; k <= int'(l); k++) begin
                a = b + AW'(k);
                e.data = f(a);
                e.last = (k == int'(l));
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout actual=pending %0d busy %b required=pending 0 busy 0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        int            mode;
        int            exp_count;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_final;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int t0, ta, tb, first_ov, lp, s, expect_words;
        logic [AW-1:0] r0;
        logic [AW-1:0] rb, rl;

        vecs[0] = '{12'h010, 12'd3,  1, 4,  f(12'h010), f(12'h013)};
        vecs[1] = '{12'hFFE, 12'd3,  1, 4,  f(12'hFFE), f(12'h001)};
        vecs[2] = '{12'h7A0, 12'd0,  2, 1,  f(12'h7A0), f(12'h7A0)};
        vecs[3] = '{12'hFFF, 12'd1,  2, 2,  f(12'hFFF), f(12'h000)};
        vecs[4] = '{12'h123, 12'd20, 3, 21, f(12'h123), f(12'h137)};

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clock);
        #1;

        // Latency and busy fall: first word at t0+4, four back-to-back pops
        ready_mode = 1;
        burst_cnt  = 0;
        send_cmd(12'h010, 12'd3, t0);
        chk("raddr_first", 64'(mem_raddr), 64'h010);
        first_ov = -1;
        lp = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready && out_last) begin
                lp = cyc;
                chk("busy_at_last_pop", 64'(busy), 64'd1);
                @(negedge clock);
                chk("busy_after_last_pop", 64'(busy), 64'd0);
                break;
            end
        end
        chk("first_valid_cycle", 64'(first_ov - t0), 64'd4);
        chk("last_pop_cycle", 64'(lp - t0), 64'd7);
        @(posedge clock);
        #1;
        wait_done(50);
        chk("lat_count", 64'(burst_cnt), 64'd4);

        // Credit stall with consumer blocked, then toggled drain
        ready_mode = 0;
        @(posedge clock);
        #1 burst_cnt = 0;
        send_cmd(12'h300, 12'd15, t0);
        repeat (12) @(negedge clock);
        r0 = mem_raddr;
        repeat (8) @(negedge clock);
        chk("stall_raddr_held", 64'(mem_raddr), 64'(r0));
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_no_pops", 64'(burst_cnt), 64'd0);
        chk("stall_pending", 64'(exp_q.size()), 64'd16);
        @(posedge clock);
        #1 ready_mode = 3;
        wait_done(300);
        chk("stall_count", 64'(burst_cnt), 64'd16);
        chk("stall_final", burst_final, f(12'h30F));

        // Back-to-back commands: one IDLE cycle between handshakes
        ready_mode = 1;
        @(posedge clock);
        #1 burst_cnt = 0;
        send_cmd(12'h100, 12'd0, ta);
        send_cmd(12'h200, 12'd1, tb);
        chk("b2b_gap", 64'(tb - ta), 64'd2);
        wait_done(50);
        chk("b2b_count", 64'(burst_cnt), 64'd3);
        chk("b2b_first", burst_first, f(12'h100));
        chk("b2b_final", burst_final, f(12'h201));

        // Asynchronous reset mid-burst
        s = n_popped;
        send_cmd(12'h500, 12'd7, t0);
        for (int i = 0; i < 50 && n_popped < s + 3; i++) @(negedge clock);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_last", 64'(out_last), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clock);
        #1 burst_cnt = 0;
        send_cmd(12'h040, 12'd0, t0);
        wait_done(50);
        repeat (10) @(posedge clock);
        #1;
        chk("post_rst_count", 64'(burst_cnt), 64'd1);
        chk("post_rst_word", burst_final, f(12'h040));

        // Vector table
        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].mode;
            burst_cnt  = 0;
            send_cmd(vecs[v].base, vecs[v].len, t0);
            wait_done(400);
            chk($sformatf("vec%0d_count", v), 64'(burst_cnt), 64'(vecs[v].exp_count));
            chk($sformatf("vec%0d_first", v), burst_first, vecs[v].exp_first);
            chk($sformatf("vec%0d_final", v), burst_final, vecs[v].exp_final);
        end

        // Random bursts, sometimes queued back-to-back, random back-pressure
        ready_mode   = 2;
        s            = n_popped;
        expect_words = 0;
        for (int n = 0; n < 40; n++) begin
            rb = AW'($urandom);
            rl = AW'($urandom_range(0, 40));
            expect_words += int'(rl) + 1;
            send_cmd(rb, rl, t0);
            if ($urandom_range(0, 1) == 0) wait_done(600);
        end
        wait_done(2000);
        chk("rand_total_words", 64'(n_popped - s), 64'(expect_words));

        // Whole memory in one burst
        ready_mode = 1;
        burst_cnt  = 0;
        send_cmd(12'h000, 12'hFFF, t0);
        wait_done(5000);
        chk("full_count", 64'(burst_cnt), 64'd4096);
        chk("full_first", burst_first, f(12'h000));
        chk("full_final", burst_final, f(12'hFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uram_read_streamer.md
# uram_read_streamer

Burst read engine sitting directly downstream of the team's fixed-latency URAM read port. It accepts a (base, length) command, drives sequential read addresses into the memory's `raddr`, tracks the in-flight words through a valid/last shadow pipeline matched to `READ_LATENCY`, and captures `dout` into a small output FIFO. Consumers get a ready/valid stream with `out_last`. A credit check ensures no word is ever dropped under back-pressure.

## Interface
- `DATA_WIDTH`, 64: word width; must match the URAM instance.
- `ADDRESS_WIDTH`, 12: address width; must match the URAM instance.
- `READ_LATENCY`, 2: URAM read latency in cycles; legal range is 1 or more.
- `FIFO_DEPTH`, 4: output FIFO entries; legal range is 1 or more. Sustaining 1 word/cycle requires `FIFO_DEPTH >= READ_LATENCY+2`.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: engine accepts a command.
- `cmd_base` in ADDRESS_WIDTH: first word address.
- `cmd_len` in ADDRESS_WIDTH: word count minus 1 (0 means 1 word; all-ones means 2^ADDRESS_WIDTH words).
- `mem_raddr` out ADDRESS_WIDTH: connects to URAM `raddr`.
- `mem_dout` in DATA_WIDTH: connects to URAM `dout`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out DATA_WIDTH: head word.
- `out_last` out 1: head is the final word of its burst.
- `busy` out 1: high in ISSUE, or while any word is in flight, or while the FIFO is non-empty.

## Operation
- FSM has two states, IDLE and ISSUE. Reset state is IDLE.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid&cmd_ready`: latch `addr<=cmd_base`, `remaining<=cmd_len`, go to ISSUE.
- ISSUE:
  - `cmd_ready=0`.
  - Issue condition: `occupancy + inflight < FIFO_DEPTH`, using registered values only. A same-cycle pop is not credited.
  - On issue:
    - `mem_raddr=addr`.
    - Shadow stage 0 gets valid=1 and last=(remaining==0).
    - `addr<=addr+1`, wrapping modulo 2^ADDRESS_WIDTH.
    - `remaining<=remaining-1`.
  - On the issue with remaining==0: return to IDLE. There is no drain state; the next command may be accepted while earlier words are still in flight.
- Shadow pipeline: READ_LATENCY stages of {valid, last}, shifting every cycle. `inflight` is the count of valid stages.
  - When the last stage is valid, push {`mem_dout`, last} into the FIFO.
- `mem_raddr` is registered from `addr` and holds its value on non-issue cycles. The URAM has no read enable, so its reads on those cycles are ignored because the shadow stage is invalid.
- FIFO:
  - First-word-fall-through from registered storage.
  - `out_valid = occupancy != 0`.
  - Pop on `out_valid&out_ready`.
  - Push and pop in the same cycle are legal: occupancy is unchanged and order is preserved.
  - The credit check guarantees a push never hits a full FIFO. Verification asserts this.
- No ordering or hazard logic against URAM writes: data is whatever the URAM returns under its read-first semantics.

## Timing
- Reset values:
  - `cmd_ready=0` while `reset_n` is low, then 1 once in IDLE.
  - `mem_raddr=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `busy=0`.
  - All shadow valids, occupancy, inflight and pointers are 0.
- Latency: command handshake at cycle t0, first `mem_raddr` in cycle t0+1, `mem_dout` valid in cycle t0+1+READ_LATENCY, `out_valid` in cycle t0+2+READ_LATENCY. With defaults, that is t0+4.
- Throughput: 1 word/cycle with `out_ready` held high and `FIFO_DEPTH >= READ_LATENCY+2`. There is one bubble cycle between back-to-back commands (the IDLE cycle).
- Back-pressure: issue stalls once occupancy+inflight reaches FIFO_DEPTH. Issue resumes the cycle after the pop that frees a credit.
- `out_data`/`out_last` are stable while `out_valid & !out_ready`.
- Reset mid-burst is asynchronous: in-flight words and FIFO contents are discarded and the FSM goes to IDLE. No `out_last` is emitted for the aborted burst.

## Test plan
- Memory preloaded with `mem[a]=a`. Command base=0x010, len=3, `out_ready=1` -> `out_data` is 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting t0+4, with `out_last` only on 0x13. `busy` falls the cycle after the last pop.
- Command base=0xFFE, len=3 -> words 0xFFE, 0xFFF, 0x000, 0x001; address wraps.
- Command len=15 with `out_ready=0` -> exactly FIFO_DEPTH (4) words are captured and issue stalls; no overflow assert fires. Then toggle `out_ready` 1-0-1-0 -> all 16 words arrive in order and `out_last` is on word 15.
- Back-to-back commands (base=0x100, len=0) then (base=0x200, len=1) -> `cmd_ready` is low 1 cycle between them. Outputs are 0x100(last), 0x200, 0x201(last).
- Assert `reset_n=0` for 1 cycle mid-burst (len=7, after 3 words are out) -> `out_valid=0` immediately and `cmd_ready=1` after release. A new command base=0x040, len=0 returns only 0x040 with last.
- len=0xFFF (full memory) -> 4096 words in address order, `out_last` on the final word only.
